// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared types and default sizes for the register-file dump engine.
package regfile_dump_ctrl_pkg;

  localparam int DUMP_NUM_REGS = 32;
  localparam int DUMP_DATA_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    READ,
    SEND,
    DONE
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Valid/ready dump stream carrying one PC header or register beat at a time.
interface regfile_dump_ctrl_if #(
  parameter int DATA_W = regfile_dump_ctrl_pkg::DUMP_DATA_W,
  parameter int ADDR_W = $clog2(regfile_dump_ctrl_pkg::DUMP_NUM_REGS)
);

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_idx;
  logic              dump_hdr;
  logic              dump_last;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_idx,
    output dump_hdr,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_idx,
    input  dump_hdr,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Halt-triggered register-file dump engine: streams an optional PC header and
// x0..x(NUM_REGS-1) over a valid/ready port while holding the core stalled.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = DUMP_NUM_REGS,
  parameter int DATA_W     = DUMP_DATA_W,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter bit INCLUDE_PC = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt_trig,
  input  logic [DATA_W-1:0]   pc_in,
  output logic [ADDR_W-1:0]   top_regfile_addr,
  input  logic [DATA_W-1:0]   top_regfile_data,
  regfile_dump_ctrl_if.master dump,
  output logic                core_stall,
  output logic                dump_done,
  output logic                trig_dropped
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              trig_dropped_q, trig_dropped_d;
  logic              is_last;

  assign is_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      data_q         <= '0;
      trig_dropped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      data_q         <= data_d;
      trig_dropped_q <= trig_dropped_d;
    end
  end

  // data_q doubles as the PC latch for the header beat, so the payload is
  // only ever loaded outside the valid states and stays stable under backpressure.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    data_d         = data_q;
    trig_dropped_d = trig_dropped_q | (halt_trig && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (halt_trig) begin
          idx_d = '0;
          if (INCLUDE_PC) begin
            data_d  = pc_in;
            state_d = HDR;
          end else begin
            state_d = READ;
          end
        end
      end
      HDR: begin
        if (dump.dump_ready) state_d = READ;
      end
      READ: begin
        data_d  = top_regfile_data;
        state_d = SEND;
      end
      SEND: begin
        if (dump.dump_ready) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dump.dump_valid  = (state_q == HDR) || (state_q == SEND);
    dump.dump_data   = data_q;
    dump.dump_hdr    = (state_q == HDR);
    dump.dump_idx    = (state_q == SEND) ? idx_q : '0;
    dump.dump_last   = (state_q == SEND) && is_last;
    top_regfile_addr = ((state_q == READ) || (state_q == SEND)) ? idx_q : '0;
    core_stall       = (state_q != IDLE);
    dump_done        = (state_q == DONE);
    trig_dropped     = trig_dropped_q;
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: table-driven dumps on a PC-header instance,
// then reset-abort, no-header and level-trigger sequences.
module tb_regfile_dump_ctrl;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          hdr;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] pc;
    bit            rand_pc;
    bit            rand_rf;
    int            rmode;
    bit            drops;
    bit            wr;
    int            exp_beats;
    int            exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] rf [NR];

  logic          trig  [2];
  logic [DW-1:0] pc    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] rdata [2];
  logic          stall [2];
  logic          done  [2];
  logic          drop  [2];
  logic          rdy   [2];
  logic          vld   [2];
  logic [DW-1:0] dat   [2];
  logic [AW-1:0] idx   [2];
  logic          hdr   [2];
  logic          last  [2];

  regfile_dump_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  regfile_dump_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  assign rdata[0] = rf[addr[0]];
  assign rdata[1] = rf[addr[1]];
  assign if0.dump_ready = rdy[0];
  assign if1.dump_ready = rdy[1];
  assign vld[0]  = if0.dump_valid;
  assign vld[1]  = if1.dump_valid;
  assign dat[0]  = if0.dump_data;
  assign dat[1]  = if1.dump_data;
  assign idx[0]  = if0.dump_idx;
  assign idx[1]  = if1.dump_idx;
  assign hdr[0]  = if0.dump_hdr;
  assign hdr[1]  = if1.dump_hdr;
  assign last[0] = if0.dump_last;
  assign last[1] = if1.dump_last;

  regfile_dump_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .INCLUDE_PC(1'b1)) dut (
    .clk(clk), .rst(rst), .halt_trig(trig[0]), .pc_in(pc[0]),
    .top_regfile_addr(addr[0]), .top_regfile_data(rdata[0]), .dump(if0.master),
    .core_stall(stall[0]), .dump_done(done[0]), .trig_dropped(drop[0])
  );

  regfile_dump_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .INCLUDE_PC(1'b0)) dut_nopc (
    .clk(clk), .rst(rst), .halt_trig(trig[1]), .pc_in(pc[1]),
    .top_regfile_addr(addr[1]), .top_regfile_data(rdata[1]), .dump(if1.master),
    .core_stall(stall[1]), .dump_done(done[1]), .trig_dropped(drop[1])
  );

  // Stream monitor: accepted beats, done pulses and payload stability under backpressure.
  beat_t bq0[$];
  beat_t bq1[$];
  int    done_cnt [2] = '{0, 0};
  int    done_cyc [2] = '{0, 0};
  int    unstable [2] = '{0, 0};
  bit    pend     [2] = '{1'b0, 1'b0};
  beat_t held     [2];

  always @(negedge clk) begin
    beat_t cur;
    for (int s = 0; s < 2; s++) begin
      cur = '{data: dat[s], idx: idx[s], hdr: hdr[s], last: last[s]};
      if (rst) begin
        pend[s] = 1'b0;
      end else begin
        if (pend[s] && (!vld[s] || (cur !== held[s]))) unstable[s]++;
        if (vld[s] && rdy[s]) begin
          if (s == 0) bq0.push_back(cur);
          else        bq1.push_back(cur);
        end
        if (done[s]) begin
          done_cnt[s]++;
          done_cyc[s] = cyc;
        end
        pend[s] = vld[s] && !rdy[s];
        held[s] = cur;
      end
    end
  end

  function automatic int qsize(input int s);
    return (s == 0) ? bq0.size() : bq1.size();
  endfunction

  function automatic beat_t qget(input int s, input int i);
    return (s == 0) ? bq0[i] : bq1[i];
  endfunction

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < NR; i++) rf[i] = rnd ? $urandom : (32'hA000_0000 + 32'(i));
  endtask

  // Expected stream is a snapshot of the register file taken before the trigger;
  // must be called just after a rising edge.
  task automatic run_dump(input int s, input logic [DW-1:0] pcv, input int rmode,
                          input bit drops, input bit wr, input int exp_beats,
                          input int exp_lat, input string tag);
    beat_t exp_q[$];
    int    s0, d0, u0, c0, n, first_n, low_stall, got, a;
    bit    timed_out, p5, p20;
    logic [DW-1:0] v;
    exp_q = {};
    if (s == 0) exp_q.push_back('{data: pcv, idx: '0, hdr: 1'b1, last: 1'b0});
    for (int i = 0; i < NR; i++)
      exp_q.push_back('{data: rf[i], idx: AW'(i), hdr: 1'b0, last: (i == NR - 1)});
    s0 = qsize(s); d0 = done_cnt[s]; u0 = unstable[s];
    trig[s] = 1'b1; pc[s] = pcv; rdy[s] = 1'b1; c0 = cyc;
    n = 0; first_n = -1; low_stall = 0; timed_out = 1'b1; p5 = 1'b0; p20 = 1'b0;
    while (n < 400) begin
      @(posedge clk); #1;
      trig[s] = 1'b0;
      pc[s]   = $urandom;
      n++;
      if (done_cnt[s] != d0) begin
        timed_out = 1'b0;
        break;
      end
      if (!stall[s]) low_stall++;
      if (vld[s] && first_n < 0) first_n = n;
      case (rmode)
        0:       rdy[s] = 1'b1;
        1:       rdy[s] = ~rdy[s];
        default: rdy[s] = 1'($urandom_range(0, 1));
      endcase
      if (drops && !p5 && (qsize(s) - s0 >= 5)) begin
        trig[s] = 1'b1; p5 = 1'b1;
      end else if (drops && !p20 && (qsize(s) - s0 >= 20)) begin
        trig[s] = 1'b1; p20 = 1'b1;
      end
      if (wr) begin
        a = $urandom_range(0, NR - 1);
        v = $urandom;
        if (!(stall[0] || stall[1])) rf[a] = v;
      end
    end
    rdy[s] = 1'b1;
    chk({tag, "_timeout"}, timed_out, 1'b0);
    chk({tag, "_stall_low"}, low_stall, 0);
    chk({tag, "_first_valid"}, first_n, (s == 0) ? 1 : 2);
    got = qsize(s) - s0;
    chk({tag, "_beats"}, got, exp_beats);
    for (int i = 0; i < exp_q.size() && i < got; i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(qget(s, s0 + i)), 64'(exp_q[i]));
    chk({tag, "_unstable"}, unstable[s] - u0, 0);
    if (exp_lat != 0) chk({tag, "_done_latency"}, done_cyc[s] - c0, exp_lat);
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt[s] - d0, 1);
    chk({tag, "_no_restart"}, qsize(s) - s0, got);
    chk({tag, "_idle_stall"}, stall[s], 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    logic [DW-1:0] pcv;
    bit exp_drop;
    bit found;
    int s0, d0;

    tbl[0] = '{pc: 32'h84,  rand_pc: 0, rand_rf: 0, rmode: 0, drops: 0, wr: 0, exp_beats: NR + 1, exp_lat: 2 * NR + 2};
    tbl[1] = '{pc: 32'h84,  rand_pc: 0, rand_rf: 0, rmode: 1, drops: 0, wr: 0, exp_beats: NR + 1, exp_lat: 0};
    tbl[2] = '{pc: 32'h0,   rand_pc: 1, rand_rf: 1, rmode: 2, drops: 0, wr: 0, exp_beats: NR + 1, exp_lat: 0};
    tbl[3] = '{pc: 32'h100, rand_pc: 0, rand_rf: 0, rmode: 0, drops: 1, wr: 0, exp_beats: NR + 1, exp_lat: 2 * NR + 2};
    tbl[4] = '{pc: 32'h0,   rand_pc: 1, rand_rf: 1, rmode: 0, drops: 0, wr: 1, exp_beats: NR + 1, exp_lat: 2 * NR + 2};

    rst = 1'b1;
    trig[0] = 1'b0; trig[1] = 1'b0;
    pc[0] = '0;     pc[1] = '0;
    rdy[0] = 1'b0;  rdy[1] = 1'b0;
    preload(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vld[0], 1'b0);
    chk("rst_stall", stall[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    chk("rst_dropped", drop[0], 1'b0);
    chk("rst_addr", addr[0], '0);
    chk("rst_data", dat[0], '0);
    chk("rst_idx_hdr_last", {idx[0], hdr[0], last[0]}, '0);
    chk("rst_nopc_stall_valid", {stall[1], vld[1]}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    exp_drop = 1'b0;
    for (int t = 0; t < 5; t++) begin
      preload(tbl[t].rand_rf);
      pcv = tbl[t].rand_pc ? $urandom : tbl[t].pc;
      run_dump(0, pcv, tbl[t].rmode, tbl[t].drops, tbl[t].wr, tbl[t].exp_beats,
               tbl[t].exp_lat, $sformatf("vec%0d", t));
      exp_drop = exp_drop | tbl[t].drops;
      chk($sformatf("vec%0d_trig_dropped", t), drop[0], exp_drop);
    end

    // Reset while x12 is on the stream aborts the dump outright.
    preload(1'b0);
    s0 = qsize(0); d0 = done_cnt[0];
    trig[0] = 1'b1; pc[0] = 32'h200; rdy[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      trig[0] = 1'b0;
      if (vld[0] && !hdr[0] && idx[0] == AW'(12)) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_reached_x12", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", vld[0], 1'b0);
    chk("abort_stall", stall[0], 1'b0);
    chk("abort_addr", addr[0], '0);
    chk("abort_dropped_cleared", drop[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt[0] - d0, 0);
    chk("abort_beats", qsize(0) - s0, 13);
    chk("abort_idle", stall[0], 1'b0);
    run_dump(0, 32'h300, 0, 1'b0, 1'b0, NR + 1, 2 * NR + 2, "post_abort");

    // No-header instance.
    preload(1'b0);
    run_dump(1, 32'h84, 0, 1'b0, 1'b0, NR, 2 * NR + 1, "nopc");
    preload(1'b1);
    run_dump(1, 32'h84, 2, 1'b0, 1'b0, NR, 0, "nopc_rand");

    // Level trigger held across DONE restarts a second dump.
    s0 = qsize(1); d0 = done_cnt[1];
    rdy[1] = 1'b1; trig[1] = 1'b1; pc[1] = 32'h40;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done_cnt[1] != d0) begin
        found = 1'b1;
        break;
      end
    end
    chk("level_first_done", found, 1'b1);
    @(posedge clk); #1;
    trig[1] = 1'b0;
    chk("level_restart_stall", stall[1], 1'b1);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done_cnt[1] - d0 == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("level_second_done", found, 1'b1);
    chk("level_beats", qsize(1) - s0, 2 * NR);
    chk("level_dropped", drop[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
